// File: rtl/digit_serial_pkg.sv
// Shared definitions for the digit-serial adder: digit width, controller
// states and the helpers that derive digit count and counter width.
package digit_serial_pkg;

    // Width of one digit processed by the ripple-carry slice per cycle.
    localparam int DIGIT_W = 3;

    // Controller states: waiting for operands, stepping digits, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digits in a WIDTH-bit operand. Returns 0 for widths that
    // cannot be split into whole digits; the top refuses to elaborate then.
    function automatic int ndig(input int width);
        if (width <= 0 || (width % DIGIT_W) != 0) begin
            return 0;
        end
        return width / DIGIT_W;
    endfunction

    // Digit counter width: enough to hold NDIG-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end
        return 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand request / result response bundle for the digit-serial adder.
// The adder sits on the slave side; its user drives the master side.
interface digit_serial_adder_if #(
    parameter int WIDTH = 12
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cout
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cout
    );

endinterface

// File: rtl/digit_serial_adder_add3_slice.sv
// Combinational 3-bit ripple-carry slice: {cout, sum} = a + b + cin.
module add3_slice
    import digit_serial_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);

    logic ripple;

    // Ripple the carry through the digit one full adder at a time.
    always_comb begin
        ripple = cin;
        sum    = '0;
        for (int i = 0; i < DIGIT_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ ripple;
            ripple = (a[i] & b[i]) | (ripple & (a[i] ^ b[i]));
        end
        cout = ripple;
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses a single 3-bit slice, one digit
// per cycle, LSB digit first, with the carry held in a flop between digits.
module digit_serial_adder
    import digit_serial_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    digit_serial_adder_if.slave bus
);

    localparam int NDIG  = ndig(WIDTH);
    localparam int CNT_W = cnt_width(NDIG);

    // Refuse widths that do not split into whole digits.
    generate
        if (NDIG == 0) begin : g_bad_width
            $error("digit_serial_adder: WIDTH must be a positive multiple of 3");
        end
    endgenerate

    state_t             state_reg,  state_next;
    logic [WIDTH-1:0]   a_sh_reg,   a_sh_next;
    logic [WIDTH-1:0]   b_sh_reg,   b_sh_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               carry_reg,  carry_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;

    logic [DIGIT_W-1:0] slice_sum;
    logic               slice_cout;
    logic               last_digit;
    logic               in_ready_int;
    logic               out_valid_int;

    // The one shared slice always looks at the low digit of the operand
    // shift registers and the carry left over from the previous digit.
    add3_slice u_slice (
        .a    (a_sh_reg[DIGIT_W-1:0]),
        .b    (b_sh_reg[DIGIT_W-1:0]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign last_digit = (cnt_reg == CNT_W'(NDIG - 1));

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and handshake outputs; the ready/valid flags depend
    // only on the registered state so neither handshake loops back combinationally.
    always_comb begin
        state_next    = state_reg;
        in_ready_int  = 1'b0;
        out_valid_int = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_int = 1'b1;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_int = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath next values: capture on accept, one digit step per RUN cycle,
    // everything frozen in DONE so the result is stable under backpressure.
    always_comb begin
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        result_next = result_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_next   = bus.in_a;
                    b_sh_next   = bus.in_b;
                    carry_next  = bus.in_cin;
                    result_next = '0;
                    cnt_next    = '0;
                end
            end
            RUN: begin
                a_sh_next   = a_sh_reg >> DIGIT_W;
                b_sh_next   = b_sh_reg >> DIGIT_W;
                // New digit enters at the top; after NDIG steps the first
                // digit has walked down to bit 0.
                result_next = (result_reg >> DIGIT_W)
                            | (WIDTH'(slice_sum) << (WIDTH - DIGIT_W));
                carry_next  = slice_cout;
                // Hold at the last index rather than wrapping; accept clears it.
                if (!last_digit) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            result_reg <= result_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_sum   = result_reg;
    assign bus.out_cout  = carry_reg;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and scoreboarded checks of the digit-serial adder at WIDTH=12.
module tb_digit_serial_adder;

    localparam int W    = 12;
    localparam int NDIG = W / 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(W)) bus ();

    digit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one operand set at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin);
        @(negedge clk);
        check_val({tag, "_acc_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] es, input logic ec);
        int lat;
        start_op(tag, a, b, cin);
        wait_valid(lat);
        check_val({tag, "_lat"},  32'(lat), 32'(NDIG));
        check_val({tag, "_sum"},  32'(bus.out_sum), 32'(es));
        check_val({tag, "_cout"}, 32'(bus.out_cout), 32'(ec));
        check_val({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        $display("txn %s a=0x%03h b=0x%03h cin=%0d -> sum=0x%03h cout=%0d lat=%0d",
                 tag, a, b, cin, bus.out_sum, bus.out_cout, lat);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val({tag, "_rdy_after"}, 32'(bus.in_ready), 32'd1);
        check_val({tag, "_vld_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int sent, recvd, cyc, extra, excl_viol;
        logic pending;
        logic [W-1:0] ra, rb;
        logic rc;
        logic [W:0] exp_full;
        logic [W:0] q[$];

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check_val("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_sum",   32'(bus.out_sum),   32'd0);
        check_val("rst_out_cout",  32'(bus.out_cout),  32'd0);
        $display("txn reset released");
        rst_n = 1'b1;

        // Directed sums.
        run_op("carry_chain", 12'h0FF, 12'h001, 1'b0, 12'h100, 1'b0);
        run_op("overflow",    12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1);
        run_op("cin_only",    12'h000, 12'h000, 1'b1, 12'h001, 1'b0);
        run_op("all_ones",    12'hFFF, 12'hFFF, 1'b1, 12'hFFF, 1'b1);

        // Backpressure: result held, new requests ignored.
        start_op("bp", 12'h0AB, 12'h0CD, 1'b1);
        wait_valid(lat);
        check_val("bp_lat", 32'(lat), 32'(NDIG));
        for (int i = 0; i < 5; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_a      = 12'hFFF;
            bus.in_b      = 12'hFFF;
            bus.in_cin    = 1'b1;
            bus.out_ready = 1'b0;
            @(negedge clk);
            check_val("bp_sum",       32'(bus.out_sum),   32'h179);
            check_val("bp_cout",      32'(bus.out_cout),  32'd0);
            check_val("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check_val("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        $display("txn bp a=0x0ab b=0x0cd cin=1 -> sum=0x%03h cout=%0d held 5 cycles",
                 bus.out_sum, bus.out_cout);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val("bp_rdy_after", 32'(bus.in_ready),  32'd1);
        check_val("bp_vld_after", 32'(bus.out_valid), 32'd0);

        // Reset in the second RUN cycle aborts the operation.
        start_op("rst_mid", 12'h555, 12'h222, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_val("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("mid_rst_out_sum",   32'(bus.out_sum),   32'd0);
        check_val("mid_rst_out_cout",  32'(bus.out_cout),  32'd0);
        repeat (3) @(negedge clk);
        check_val("mid_rst_hold_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        $display("txn reset during RUN");
        run_op("post_rst", 12'h123, 12'h456, 1'b0, 12'h579, 1'b0);

        // Random back-to-back traffic against a scoreboard.
        sent = 0; recvd = 0; cyc = 0; extra = 0; excl_viol = 0;
        pending = 1'b0;
        ra = '0; rb = '0; rc = 1'b0;
        while (recvd < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (bus.in_ready && bus.out_valid) excl_viol++;

            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    extra++;
                end else begin
                    exp_full = q.pop_front();
                    check_val("rnd_result", 32'({bus.out_cout, bus.out_sum}), 32'(exp_full));
                    $display("txn rnd %0d -> sum=0x%03h cout=%0d exp=0x%04h",
                             recvd, bus.out_sum, bus.out_cout, exp_full);
                    recvd++;
                end
            end

            if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
                ra      = W'($urandom_range(0, 4095));
                rb      = W'($urandom_range(0, 4095));
                rc      = 1'($urandom_range(0, 1));
                pending = 1'b1;
            end
            bus.in_valid = pending;
            bus.in_a     = ra;
            bus.in_b     = rb;
            bus.in_cin   = rc;
            if (pending && bus.in_ready) begin
                q.push_back({1'b0, ra} + {1'b0, rb} + (W+1)'(rc));
                sent++;
                pending = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_val("rnd_received",  32'(recvd),    32'd1000);
        check_val("rnd_extra",     32'(extra),    32'd0);
        check_val("rnd_leftover",  32'(q.size()), 32'd0);
        check_val("rnd_exclusive", 32'(excl_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
